// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execute-stage ALU for the MIPS datapath. AND/OR/ADD/SUB/SLT finish in one
// cycle. MUL is an iterative shift-add multiply that takes WIDTH iteration
// cycles. A start/busy/done handshake lets the pipeline controller stall
// while a multiply is running.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset; aborts any operation
//   start        operation request, sampled only while busy is low
//   ALU_Control  3-bit operation code from the ALU control decoder
//   a, b         WIDTH-bit operands (rs, rt/immediate)
//   result       registered result, held between completions
//   zero         registered flag, high when result is zero
//   busy         high while a MUL is iterating
//   done         one-cycle pulse on each result update
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       ALU_Control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_MUL  = 1'b1;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  // Single-cycle operations; unused codes (011, 111) fall through to ADD.
  function automatic logic [WIDTH-1:0] alu_single(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_ADD:  r = x + y;
      OP_SUB:  r = x - y;
      OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      default: r = x + y;
    endcase
    return r;
  endfunction

  logic [0:0]       state_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             done_r;

  logic [WIDTH-1:0] single_s;
  logic [WIDTH-1:0] acc_sum_s;

  // Combinational datapath: single-cycle result and the next accumulator value.
  always_comb begin
    single_s = alu_single(ALU_Control, a, b);
    if (mplier_r[0]) begin
      acc_sum_s = acc_r + mcand_r;
    end else begin
      acc_sum_s = acc_r;
    end
  end

  // Control FSM, multiply datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      mcand_r  <= ZERO_W;
      mplier_r <= ZERO_W;
      acc_r    <= ZERO_W;
      cnt_r    <= {CW{1'b0}};
      result_r <= ZERO_W;
      zero_r   <= 1'b1;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (ALU_Control == OP_MUL) begin
              // Operands are captured here so a/b may change during the multiply.
              mcand_r  <= a;
              mplier_r <= b;
              acc_r    <= ZERO_W;
              cnt_r    <= {CW{1'b0}};
              state_r  <= ST_MUL;
            end else begin
              result_r <= single_s;
              zero_r   <= (single_s == ZERO_W);
              done_r   <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          acc_r    <= acc_sum_s;
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CNT_ONE;
          // Last iteration: the sum computed this cycle is the final product.
          if (cnt_r == CNT_LAST) begin
            result_r <= acc_sum_s;
            zero_r   <= (acc_sum_s == ZERO_W);
            done_r   <= 1'b1;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign result = result_r;
  assign zero   = zero_r;
  assign busy   = (state_r == ST_MUL);
  assign done   = done_r;

endmodule
